// File: rtl/midi_note_decoder.sv
// midi_note_decoder: parses a raw MIDI byte stream into a monophonic,
// last-note-priority note command (o_cmd / o_midi / o_velocity) for phase_bank.
// Handles Note On/Off, velocity-zero Note Off, running status, interleaved
// real-time bytes and SysEx skipping.
// Build option: define MIDI_CHANNEL_FILTER_EN to accept only channel CHANNEL;
// leave it undefined for omni mode (every channel executes).
module midi_note_decoder #(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_byte,
  input  logic       i_valid,
  output logic       o_cmd,
  output logic [6:0] o_midi,
  output logic [6:0] o_velocity,
  output logic       o_event
);

`ifdef MIDI_CHANNEL_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // no running status, data bytes discarded
    WAIT_D1 = 2'd1,  // running status held, waiting for note byte
    WAIT_D2 = 2'd2   // note latched, waiting for velocity byte
  } state_e;

  state_e     state_q, state_d;
  logic       note_on_q, note_on_d;  // 1 = Note On, 0 = Note Off
  logic       match_q, match_d;      // channel of running status is accepted
  logic [6:0] note_q, note_d;        // latched first data byte
  logic       cmd_q, cmd_d;
  logic [6:0] midi_q, midi_d;
  logic [6:0] vel_q, vel_d;
  logic       event_q, event_d;

  logic is_realtime;
  logic is_note_status;

  assign is_realtime    = (i_byte[7:3] == 5'b11111);  // 0xF8-0xFF
  assign is_note_status = (i_byte[7:5] == 3'b100);    // 0x8n / 0x9n

  // Next-state and output computation for the parser and the voice command.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    note_on_d = note_on_q;
    match_d   = match_q;
    note_d    = note_q;
    cmd_d     = cmd_q;
    midi_d    = midi_q;
    vel_d     = vel_q;
    event_d   = 1'b0;

    if (i_valid) begin
      if (i_byte[7]) begin
        if (is_realtime) begin
          // Real-time bytes pass through without disturbing the parser.
        end else if (is_note_status) begin
          // A new note status replaces any pending partial message.
          note_on_d = i_byte[4];
          match_d   = !FILTER_EN || (i_byte[3:0] == CHANNEL);
          state_d   = WAIT_D1;
        end else begin
          // Other channel messages, SysEx and system common cancel running status.
          state_d = IDLE;
        end
      end else begin
        unique case (state_q)
          WAIT_D1: begin
            note_d  = i_byte[6:0];
            state_d = WAIT_D2;
          end
          WAIT_D2: begin
            state_d = WAIT_D1;  // running status: next data byte is a new note
            if (match_q) begin
              if (note_on_q && (i_byte[6:0] != 7'd0)) begin
                // Note On always takes the voice, including same-note retrigger.
                cmd_d   = 1'b1;
                midi_d  = note_q;
                vel_d   = i_byte[6:0];
                event_d = 1'b1;
              end else if (cmd_q && (note_q == midi_q)) begin
                // Release only silences the note that is actually sounding.
                cmd_d   = 1'b0;
                event_d = 1'b1;
              end
            end
          end
          default: begin
            // IDLE: stray data bytes are dropped.
          end
        endcase
      end
    end
  end

  // State and registered outputs; synchronous reset wins over i_valid.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!i_rst_n) begin
      state_q   <= IDLE;
      note_on_q <= 1'b0;
      match_q   <= 1'b0;
      note_q    <= 7'd0;
      cmd_q     <= 1'b0;
      midi_q    <= 7'd0;
      vel_q     <= 7'd0;
      event_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      note_on_q <= note_on_d;
      match_q   <= match_d;
      note_q    <= note_d;
      cmd_q     <= cmd_d;
      midi_q    <= midi_d;
      vel_q     <= vel_d;
      event_q   <= event_d;
    end
  end

  assign o_cmd      = cmd_q;
  assign o_midi     = midi_q;
  assign o_velocity = vel_q;
  assign o_event    = event_q;

endmodule
